// File: rtl/program_loader.sv
// program_loader: writer side of the program RAM.
// Takes a byte stream (valid/ready), reads a 16-bit big-endian word count,
// then assembles big-endian 16-bit instruction words and writes each one
// through the memory controller's write path. The execution driver stays
// disabled until a complete image has been written.
// Optional build macro: LOADER_CHECKSUM_EN adds a trailing checksum byte
// (XOR of all payload bytes) that must match before the image is accepted.
module program_loader #(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned MEMORY_DEPTH  = 64,
  parameter int unsigned BASE_ADDRESS  = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  output logic                     mem_write,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_data,
  output logic [15:0]              words_written,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     execution_enable
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] BASE = ADDRESS_WIDTH'(BASE_ADDRESS);

  state_t                   state_q, state_d;
  logic [15:0]              length_q, length_d;
  logic [7:0]               wordHi_q, wordHi_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [15:0]              count_q, count_d;
  logic                     ready_q, memWrite_q, busy_q, done_q, error_q, execEnable_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]               checksum_q, checksum_d;
`endif

  logic        accept;
  logic [15:0] lengthFull;
  logic [15:0] countInc;

  assign accept     = byte_valid && ready_q;
  assign lengthFull = {length_q[15:8], byte_in};
  assign countInc   = count_q + 16'd1;

  // Next-state and datapath decisions; every transfer is qualified by accept.
  always_comb begin
    state_d   = state_q;
    length_d  = length_q;
    wordHi_d  = wordHi_q;
    address_d = address_q;
    data_d    = data_q;
    count_d   = count_q;
`ifdef LOADER_CHECKSUM_EN
    checksum_d = checksum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_HI;
          count_d = '0;
`ifdef LOADER_CHECKSUM_EN
          checksum_d = '0;
`endif
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          length_d = {byte_in, length_q[7:0]};
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          length_d = lengthFull;
          if (lengthFull == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else if (32'(lengthFull) > MEMORY_DEPTH) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DAT_HI;
          end
        end
      end
      S_DAT_HI: begin
        if (accept) begin
          wordHi_d = byte_in;
`ifdef LOADER_CHECKSUM_EN
          checksum_d = checksum_q ^ byte_in;
`endif
          state_d = S_DAT_LO;
        end
      end
      S_DAT_LO: begin
        if (accept) begin
          data_d    = DATA_WIDTH'({wordHi_q, byte_in});
          address_d = BASE + ADDRESS_WIDTH'(count_q);
`ifdef LOADER_CHECKSUM_EN
          checksum_d = checksum_q ^ byte_in;
`endif
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        count_d = countInc;
        if (countInc == length_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DAT_HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          state_d = (byte_in == checksum_q) ? S_DONE : S_ERROR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and output flags; flags are registered from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      length_q     <= '0;
      wordHi_q     <= '0;
      address_q    <= '0;
      data_q       <= '0;
      count_q      <= '0;
      ready_q      <= 1'b0;
      memWrite_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      execEnable_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      length_q     <= length_d;
      wordHi_q     <= wordHi_d;
      address_q    <= address_d;
      data_q       <= data_d;
      count_q      <= count_d;
      ready_q      <= state_d inside {S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_CHK};
      memWrite_q   <= (state_d == S_WRITE);
      busy_q       <= !(state_d inside {S_IDLE, S_DONE, S_ERROR});
      done_q       <= (state_d == S_DONE);
      error_q      <= (state_d == S_ERROR);
      execEnable_q <= (state_d == S_DONE);
`ifdef LOADER_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end

  assign byte_ready       = ready_q;
  assign mem_write        = memWrite_q;
  assign mem_address      = address_q;
  assign mem_data         = data_q;
  assign words_written    = count_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign execution_enable = execEnable_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: self-checking bench for program_loader.
// Streams images into the loader and compares the observed RAM writes and
// status flags against expectations derived from the loader's rules.
module tb_program_loader;

  localparam int DEPTH = 64;
  localparam logic [15:0] BASE = 16'h0000;
`ifdef LOADER_CHECKSUM_EN
  localparam int CHK_EXTRA = 1;
`else
  localparam int CHK_EXTRA = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byteIn = 8'h00;
  logic        byteValid = 1'b0;
  logic        byte_ready, mem_write, busy, done, error, execution_enable;
  logic [15:0] mem_address, mem_data, words_written;

  int errors = 0;
  int checks = 0;
  int cycleCnt = 0;
  int firstAccept = 0;
  bit firstPending = 0;
  int readyInWrite = 0;
  logic [15:0] wrAddr[$];
  logic [15:0] wrData[$];
  logic [7:0]  payload[$];

  program_loader #(
    .ADDRESS_WIDTH(16), .DATA_WIDTH(16), .MEMORY_DEPTH(DEPTH), .BASE_ADDRESS(0)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .byte_in(byteIn), .byte_valid(byteValid), .byte_ready(byte_ready),
    .mem_write(mem_write), .mem_address(mem_address), .mem_data(mem_data),
    .words_written(words_written), .busy(busy), .done(done), .error(error),
    .execution_enable(execution_enable)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Cycle counter used to time loads.
  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  // Record every write strobe seen, and whether the loader claimed ready during it.
  always @(negedge clock) begin
    if (mem_write) begin
      wrAddr.push_back(mem_address);
      wrData.push_back(mem_data);
      if (byte_ready) readyInWrite++;
    end
  end

  // Offer one byte (called at a negedge) until it is taken or the bound expires.
  task automatic sendByte(input logic [7:0] b, input bit toggle, output bit stuck);
    int guard = 0;
    stuck = 0;
    if (toggle) begin
      byteValid = 1'b0;
      @(negedge clock);
    end
    byteIn = b;
    byteValid = 1'b1;
    while (!byte_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (!byte_ready) begin
      stuck = 1;
      byteValid = 1'b0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    if (firstPending) begin
      firstAccept = cycleCnt;
      firstPending = 0;
    end
  endtask

  // Run one whole load from a start pulse to done/error; payload comes from the queue.
  task automatic applyStimulus(input logic [15:0] len, input bit toggle, input bit badChk,
                               output int delta, output bit timedOut);
    bit stuck;
    bit anyStuck = 0;
    int guard = 0;
    logic [7:0] chk = 8'h00;
    wrAddr.delete();
    wrData.delete();
    readyInWrite = 0;
    timedOut = 0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    firstPending = 1;
    sendByte(len[15:8], toggle, stuck); anyStuck |= stuck;
    sendByte(len[7:0], toggle, stuck);  anyStuck |= stuck;
    if (len != 0 && int'(len) <= DEPTH) begin
      for (int i = 0; i < 2 * int'(len); i++) begin
        sendByte(payload[i], toggle, stuck);
        anyStuck |= stuck;
      end
    end
    if (CHK_EXTRA == 1 && int'(len) <= DEPTH) begin
      for (int i = 0; i < 2 * int'(len); i++) chk ^= payload[i];
      if (badChk) chk ^= 8'h01;
      sendByte(chk, toggle, stuck);
      anyStuck |= stuck;
    end
    byteValid = 1'b0;
    while (!(done || error) && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    timedOut = anyStuck || !(done || error);
    delta = cycleCnt - firstAccept;
  endtask

  task automatic test_reset;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if ({busy, done, error, execution_enable, byte_ready, mem_write} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 000000",
               {busy, done, error, execution_enable, byte_ready, mem_write});
    end
    checks++;
    if (words_written !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_words: got %0d expected 0", words_written);
    end
    checks++;
    if ({mem_address, mem_data} !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_bus: got %h expected 0", {mem_address, mem_data});
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic_stream;
    int delta;
    bit to;
    payload = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h0F, 8'hF0};
    applyStimulus(16'd3, 0, 0, delta, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL basic_timeout: got timeout expected completion"); end
    checks++;
    if ({done, execution_enable, error, busy} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL basic_flags: got %b expected 1100", {done, execution_enable, error, busy});
    end
    checks++;
    if (words_written !== 16'd3) begin
      errors++;
      $display("[TB] FAIL basic_words: got %0d expected 3", words_written);
    end
    checks++;
    if (delta != 3 * 3 + 1 + CHK_EXTRA) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d expected %0d", delta, 3 * 3 + 1 + CHK_EXTRA);
    end
    checks++;
    if (wrAddr.size() != 3) begin
      errors++;
      $display("[TB] FAIL basic_write_count: got %0d expected 3", wrAddr.size());
    end
    for (int i = 0; i < wrAddr.size() && i < 3; i++) begin
      logic [15:0] ea;
      logic [15:0] ed;
      ea = BASE + 16'(i);
      ed = {payload[2*i], payload[2*i+1]};
      checks++;
      if (wrAddr[i] !== ea || wrData[i] !== ed) begin
        errors++;
        $display("[TB] FAIL basic_write%0d: got %h@%h expected %h@%h", i, wrData[i], wrAddr[i], ed, ea);
      end
    end
  endtask

  task automatic test_toggle_valid;
    int delta;
    bit to;
    payload = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h0F, 8'hF0};
    applyStimulus(16'd3, 1, 0, delta, to);
    checks++;
    if (to || done !== 1'b1 || words_written !== 16'd3) begin
      errors++;
      $display("[TB] FAIL toggle_end: got done=%b words=%0d to=%0d expected done=1 words=3",
               done, words_written, to);
    end
    checks++;
    if (readyInWrite != 0) begin
      errors++;
      $display("[TB] FAIL toggle_ready_in_write: got %0d expected 0", readyInWrite);
    end
    checks++;
    if (wrAddr.size() != 3) begin
      errors++;
      $display("[TB] FAIL toggle_write_count: got %0d expected 3", wrAddr.size());
    end
    for (int i = 0; i < wrAddr.size() && i < 3; i++) begin
      logic [15:0] ea;
      logic [15:0] ed;
      ea = BASE + 16'(i);
      ed = {payload[2*i], payload[2*i+1]};
      checks++;
      if (wrAddr[i] !== ea || wrData[i] !== ed) begin
        errors++;
        $display("[TB] FAIL toggle_write%0d: got %h@%h expected %h@%h", i, wrData[i], wrAddr[i], ed, ea);
      end
    end
  endtask

  task automatic test_oversize;
    int delta;
    bit to;
    payload.delete();
    applyStimulus(16'h0041, 0, 0, delta, to);
    checks++;
    if (to || {error, done, execution_enable, byte_ready, busy} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL oversize_flags: got %b expected 10000",
               {error, done, execution_enable, byte_ready, busy});
    end
    checks++;
    if (wrAddr.size() != 0) begin
      errors++;
      $display("[TB] FAIL oversize_writes: got %0d expected 0", wrAddr.size());
    end
    payload = '{8'h5A, 8'hA5};
    applyStimulus(16'd1, 0, 0, delta, to);
    checks++;
    if (to || {done, error, execution_enable} !== 3'b101 || words_written !== 16'd1) begin
      errors++;
      $display("[TB] FAIL oversize_recover: got flags=%b words=%0d expected flags=101 words=1",
               {done, error, execution_enable}, words_written);
    end
    checks++;
    if (wrAddr.size() != 1 || wrAddr[0] !== BASE || wrData[0] !== 16'h5AA5) begin
      errors++;
      $display("[TB] FAIL oversize_recover_write: got %0d writes expected one 5aa5@%h", wrAddr.size(), BASE);
    end
  endtask

  task automatic test_zero_length;
    int delta;
    bit to;
    payload.delete();
    applyStimulus(16'd0, 0, 0, delta, to);
    checks++;
    if (to || {done, execution_enable, error} !== 3'b110 || wrAddr.size() != 0) begin
      errors++;
      $display("[TB] FAIL zero_done: got flags=%b writes=%0d expected flags=110 writes=0",
               {done, execution_enable, error}, wrAddr.size());
    end
    checks++;
    if (delta != 1 + CHK_EXTRA) begin
      errors++;
      $display("[TB] FAIL zero_latency: got %0d expected %0d", delta, 1 + CHK_EXTRA);
    end
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if ({execution_enable, busy, done} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL zero_restart: got %b expected 010", {execution_enable, busy, done});
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_midload;
    bit stuck;
    int delta;
    bit to;
    payload = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    wrAddr.delete();
    wrData.delete();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    firstPending = 0;
    sendByte(8'h00, 0, stuck);
    sendByte(8'h05, 0, stuck);
    for (int i = 0; i < 5; i++) sendByte(payload[i], 0, stuck);
    byteValid = 1'b0;
    checks++;
    if (wrAddr.size() != 2 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midload_progress: got writes=%0d busy=%b expected writes=2 busy=1",
               wrAddr.size(), busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, error, execution_enable, byte_ready, mem_write} !== 6'b0 || words_written !== 16'd0) begin
      errors++;
      $display("[TB] FAIL midload_async_reset: got flags=%b words=%0d expected 000000 and 0",
               {busy, done, error, execution_enable, byte_ready, mem_write}, words_written);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    payload = '{8'hC0, 8'hDE, 8'hBE, 8'hEF};
    applyStimulus(16'd2, 0, 0, delta, to);
    checks++;
    if (to || done !== 1'b1 || wrAddr.size() != 2 || wrAddr[0] !== BASE || wrData[0] !== 16'hC0DE) begin
      errors++;
      $display("[TB] FAIL midload_reload: got done=%b writes=%0d expected done=1 first c0de@%h",
               done, wrAddr.size(), BASE);
    end
  endtask

  task automatic test_random;
    int delta;
    bit to;
    int len;
    bit toggle;
    for (int it = 0; it < 5; it++) begin
      len = (it == 3) ? int'($urandom_range(65, 300)) : int'($urandom_range(1, 8));
      toggle = 1'($urandom_range(0, 1));
      payload.delete();
      for (int i = 0; i < 2 * len; i++) payload.push_back(8'($urandom_range(0, 255)));
      applyStimulus(16'(len), toggle, 0, delta, to);
      if (len > DEPTH) begin
        checks++;
        if (to || {error, done, execution_enable} !== 3'b100 || wrAddr.size() != 0) begin
          errors++;
          $display("[TB] FAIL random%0d_reject: got flags=%b writes=%0d expected 100 and 0",
                   it, {error, done, execution_enable}, wrAddr.size());
        end
      end else begin
        checks++;
        if (to || {done, error} !== 2'b10 || words_written !== 16'(len)) begin
          errors++;
          $display("[TB] FAIL random%0d_end: got flags=%b words=%0d expected 10 words=%0d",
                   it, {done, error}, words_written, len);
        end
        checks++;
        if (wrAddr.size() != len) begin
          errors++;
          $display("[TB] FAIL random%0d_count: got %0d expected %0d", it, wrAddr.size(), len);
        end
        for (int i = 0; i < wrAddr.size() && i < len; i++) begin
          logic [15:0] ea;
          logic [15:0] ed;
          ea = BASE + 16'(i);
          ed = {payload[2*i], payload[2*i+1]};
          checks++;
          if (wrAddr[i] !== ea || wrData[i] !== ed) begin
            errors++;
            $display("[TB] FAIL random%0d_write%0d: got %h@%h expected %h@%h",
                     it, i, wrData[i], wrAddr[i], ed, ea);
          end
        end
      end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum;
    int delta;
    bit to;
    payload = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    applyStimulus(16'd2, 0, 0, delta, to);
    checks++;
    if (to || {done, error, execution_enable} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL checksum_good: got %b expected 101", {done, error, execution_enable});
    end
    applyStimulus(16'd2, 0, 1, delta, to);
    checks++;
    if (to || {done, error, execution_enable} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL checksum_bad: got %b expected 010", {done, error, execution_enable});
    end
  endtask
`endif

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_basic_stream();
    test_toggle_valid();
    test_oversize();
    test_zero_length();
    test_reset_midload();
    test_random();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Writer side of program RAM. The PC fetch path only reads program RAM; this block fills it at run time.
- Accepts a byte stream through a valid/ready handshake and assembles big-endian 16-bit instruction words.
- Drives the memory controller's input_address/input_data/write path.
- Holds the execution driver disabled until a complete image is written, then releases it.

Parameters:
ADDRESS_WIDTH, 16, width of mem_address
DATA_WIDTH, 16, width of instruction word (fixed at 2 bytes; other values unsupported)
MEMORY_DEPTH, 64, program RAM capacity in words; larger images are rejected
BASE_ADDRESS, 0, address of first written word

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  begin a load; sampled only in IDLE, DONE or ERROR
byte_in  input  8  stream byte
byte_valid  input  1  byte_in valid
byte_ready  output  1  loader can accept byte this cycle
mem_write  output  1  one-cycle program RAM write strobe (maps to PRAM rw = write)
mem_address  output  ADDRESS_WIDTH  write address
mem_data  output  DATA_WIDTH  write data
words_written  output  16  count of words written in current load
busy  output  1  load in progress
done  output  1  image complete and valid
error  output  1  load rejected
execution_enable  output  1  drives execution_driver.enable; high only in DONE

Behaviour:
- Reset (async): state=IDLE. All outputs 0; words_written=0.
- Byte transfer occurs on a rising edge with byte_valid && byte_ready. byte_ready is a registered-state decode: high only in LEN_HI, LEN_LO, DAT_HI, DAT_LO (and CHK when enabled).
- States and transitions:
  - IDLE: start -> LEN_HI; clear words_written, done, error.
  - LEN_HI: accept byte into length[15:8] -> LEN_LO.
  - LEN_LO: accept byte into length[7:0]. Then:
    - length==0 -> DONE.
    - length>MEMORY_DEPTH -> ERROR.
    - otherwise -> DAT_HI.
  - DAT_HI: accept byte into word[15:8] -> DAT_LO.
  - DAT_LO: accept byte into word[7:0] -> WRITE.
  - WRITE (one cycle, byte_ready=0):
    - mem_write=1; mem_address=BASE_ADDRESS+words_written (wraps mod 2^ADDRESS_WIDTH); mem_data=assembled word.
    - Next edge: words_written+1.
    - If new count==length -> DONE (or CHK when enabled); else -> DAT_HI.
  - DONE: done=1, execution_enable=1, busy=0. start -> LEN_HI; execution_enable drops the cycle after start is sampled.
  - ERROR: error=1, execution_enable=0, byte_ready=0. Left only via start (-> LEN_HI) or reset.
- busy=1 in every state except IDLE, DONE, ERROR.
- start is ignored while busy. Stalled byte_valid simply holds the state; there is no timeout.
- Reset mid-load: returns to IDLE immediately. A partially written RAM is not erased and execution_enable stays 0.
- mem_address/mem_data may hold stale values when mem_write=0; consumers qualify on mem_write.
- Minimum load time for N words: 2 + 3N cycles.

Optional Feature:
LOADER_CHECKSUM_EN:
- Defined:
  - After the last WRITE the loader enters CHK and accepts one byte.
  - The byte is compared with the XOR of all payload bytes; length bytes are excluded.
  - Match -> DONE. Mismatch -> ERROR.
  - length==0 still goes through CHK, with expected value 0x00.
- Undefined: no CHK state; the stream ends after the last data byte.

Test Plan:
- Reset asserted during DAT_LO of word 3 -> outputs 0 asynchronously, state IDLE, execution_enable=0; a following start reloads from BASE_ADDRESS.
- start, stream 00 03 | 12 34 | AB CD | 0F F0 with byte_valid held high -> writes 0x1234@0, 0xABCD@1, 0x0FF0@2, one mem_write pulse each; done=1 and execution_enable=1 at cycle 11 after the first byte is accepted; words_written=3.
- Same stream with byte_valid toggling every other cycle -> identical writes, no byte dropped or duplicated; byte_ready=0 during each WRITE cycle.
- Length 00 41 with MEMORY_DEPTH=64 -> ERROR after LEN_LO, no mem_write, error=1, byte_ready=0; a later start with length 00 01 succeeds.
- Length 00 00 -> DONE immediately, no writes. Then start in DONE -> execution_enable falls the next cycle and busy=1.
- With LOADER_CHECKSUM_EN: payload 12 34 AB CD plus checksum 0x40 -> DONE; checksum 0x41 -> ERROR with execution_enable=0.
